// File: rtl/sprite_plot_arbiter_pkg.sv
// rtl/sprite_plot_arbiter_pkg.sv - shared state encoding, screen bounds and field widths
package sprite_plot_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BURST   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int SCREEN_X = 320;
  localparam int SCREEN_Y = 240;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int C_W      = 12;

endpackage

// File: rtl/sprite_plot_arbiter_rr_pick.sv
// rtl/sprite_plot_arbiter_rr_pick.sv - combinational round-robin winner select
module rr_pick #(
  parameter int NUM_REQ = 6,
  parameter int PW      = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               any
);

  // Scan from rr_ptr upward with wrap; the first set request wins.
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        win[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_plot_arbiter.sv
// rtl/sprite_plot_arbiter.sv - round-robin burst arbiter feeding a VGA pixel plotter
module sprite_plot_arbiter
  import sprite_plot_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 6,
  parameter int TIMEOUT = 1024,
  parameter int X_MAX   = SCREEN_X,
  parameter int Y_MAX   = SCREEN_Y
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     gnt,
  input  logic [NUM_REQ-1:0]     pix_valid,
  input  logic [NUM_REQ-1:0]     pix_last,
  input  logic [NUM_REQ*X_W-1:0] pix_x,
  input  logic [NUM_REQ*Y_W-1:0] pix_y,
  input  logic [NUM_REQ*C_W-1:0] pix_colour,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t             state, state_nx;
  logic [PW-1:0]      rr_ptr, g_idx, win_idx;
  logic [NUM_REQ-1:0] win;
  logic               any;
  logic [CW-1:0]      idle_cnt;
  logic               grant_load, release_adv, set_err;
  logic               accept, in_bounds;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [C_W-1:0]     sel_c;

  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .win    (win),
    .any    (any)
  );

  // Encode the one-hot winner so the held grant can index the pixel mux.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_idx = PW'(i);
    end
  end

  assign sel_x     = pix_x[g_idx*X_W +: X_W];
  assign sel_y     = pix_y[g_idx*Y_W +: Y_W];
  assign sel_c     = pix_colour[g_idx*C_W +: C_W];
  assign accept    = (state == ST_BURST) && pix_valid[g_idx] && gnt[g_idx];
  assign in_bounds = (int'(sel_x) < X_MAX) && (int'(sel_y) < Y_MAX);
  assign busy      = (state != ST_IDLE);

  // State register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state; a final pixel beats an abort, and an abort beats a timeout.
  always_comb begin
    state_nx    = state;
    grant_load  = 1'b0;
    release_adv = 1'b0;
    set_err     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any) begin
          state_nx   = ST_BURST;
          grant_load = 1'b1;
        end
      end
      ST_BURST: begin
        if (accept && pix_last[g_idx]) begin
          state_nx    = ST_RELEASE;
          release_adv = 1'b1;
        end else if (!req[g_idx]) begin
          state_nx    = ST_RELEASE;
          release_adv = 1'b1;
        end else if (!accept && idle_cnt == CW'(TIMEOUT - 1)) begin
          state_nx    = ST_RELEASE;
          release_adv = 1'b1;
          set_err     = 1'b1;
        end
      end
      ST_RELEASE: state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Grant, round-robin pointer, idle counter and sticky error.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      gnt         <= '0;
      g_idx       <= '0;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant_load) begin
        gnt   <= win;
        g_idx <= win_idx;
      end else if (release_adv) begin
        gnt    <= '0;
        rr_ptr <= (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
      end
      if (state == ST_BURST && !release_adv)
        idle_cnt <= accept ? '0 : idle_cnt + 1'b1;
      else
        idle_cnt <= '0;
      if (set_err) timeout_err <= 1'b1;
    end
  end

  // Registered pixel mux; off-screen pixels are swallowed and fields hold.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      plot <= accept && in_bounds;
      if (accept && in_bounds) begin
        x      <= sel_x;
        y      <= sel_y;
        colour <= sel_c;
      end
    end
  end

endmodule

// File: tb/tb_sprite_plot_arbiter.sv
// tb/tb_sprite_plot_arbiter.sv - randomized self-checking bench with reference model
module tb_sprite_plot_arbiter;

  localparam int N  = 6;
  localparam int TO = 16;

  logic          clk;
  logic          reset_d;
  logic [N-1:0]  req_d, valid_d, last_d;
  logic [N*9-1:0]  px_d;
  logic [N*8-1:0]  py_d;
  logic [N*12-1:0] pc_d;
  logic [N-1:0]  gnt;
  logic [8:0]    x;
  logic [7:0]    y;
  logic [11:0]   colour;
  logic          plot, busy, timeout_err;

  int n_cmp, n_bad;
  int m_phase, m_owner, m_ptr, m_run, m_err, m_plot, m_x, m_y, m_c;

  sprite_plot_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .X_MAX(320), .Y_MAX(240)) dut (
    .CLOCK_50    (clk),
    .reset       (reset_d),
    .req         (req_d),
    .gnt         (gnt),
    .pix_valid   (valid_d),
    .pix_last    (last_d),
    .pix_x       (px_d),
    .pix_y       (py_d),
    .pix_colour  (pc_d),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_run = 0; m_err = 0;
    m_plot = 0; m_x = 0; m_y = 0; m_c = 0;
  endtask

  task automatic finish_burst();
    m_phase = 2;
    m_ptr   = (m_owner + 1) % N;
    m_run   = 0;
  endtask

  // Reference behaviour for one clock edge, from the current inputs.
  task automatic model_step();
    int o, vx, vy, vc;
    bit acc, found;
    if (reset_d) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        m_plot = 0;
        found  = 0;
        for (int k = 0; k < N; k++) begin
          o = (m_ptr + k) % N;
          if (!found && req_d[o]) begin
            found = 1; m_owner = o; m_phase = 1; m_run = 0;
          end
        end
      end
      1: begin
        o   = m_owner;
        acc = valid_d[o];
        vx  = int'(px_d[o*9 +: 9]);
        vy  = int'(py_d[o*8 +: 8]);
        vc  = int'(pc_d[o*12 +: 12]);
        m_plot = (acc && vx < 320 && vy < 240) ? 1 : 0;
        if (m_plot == 1) begin m_x = vx; m_y = vy; m_c = vc; end
        m_run = acc ? 0 : m_run + 1;
        if (acc && last_d[o]) finish_burst();
        else if (!req_d[o]) finish_burst();
        else if (m_run == TO) begin finish_burst(); m_err = 1; end
      end
      default: begin
        m_phase = 0;
        m_plot  = 0;
      end
    endcase
  endtask

  task automatic step();
    logic [N-1:0] eg;
    model_step();
    @(posedge clk);
    #1;
    eg = (m_phase == 1) ? N'(1 << m_owner) : '0;
    check("gnt",    32'(gnt),         32'(eg));
    check("plot",   32'(plot),        32'(m_plot));
    check("x",      32'(x),           32'(m_x));
    check("y",      32'(y),           32'(m_y));
    check("colour", 32'(colour),      32'(m_c));
    check("busy",   32'(busy),        32'(m_phase != 0));
    check("terr",   32'(timeout_err), 32'(m_err));
  endtask

  task automatic set_pix(input int i, input int px, input int py, input int pc,
                         input bit v, input bit l);
    px_d[i*9 +: 9]   = 9'(px);
    py_d[i*8 +: 8]   = 8'(py);
    pc_d[i*12 +: 12] = 12'(pc);
    valid_d[i] = v;
    last_d[i]  = l;
  endtask

  task automatic quiet(input int cycles);
    req_d = '0; valid_d = '0; last_d = '0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic rand_inputs(input bit stall);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 31) == 0) req_d[i] = ~req_d[i];
      set_pix(i, $urandom_range(0, 330), $urandom_range(0, 250), $urandom_range(0, 4095),
              stall ? 1'b0 : 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    int exp_next, prev_phase;
    n_cmp = 0; n_bad = 0;
    req_d = '0; valid_d = '0; last_d = '0; px_d = '0; py_d = '0; pc_d = '0;
    model_reset();

    // Reset state.
    reset_d = 1'b1;
    step();
    step();
    reset_d = 1'b0;
    step();

    // Two requesters from reset: 0 first, then 1.
    req_d = 6'b000011;
    step();
    set_pix(0, 40, 30, 12'h0F0, 1'b1, 1'b1);
    step();
    valid_d = '0; last_d = '0;
    for (int i = 0; i < 4; i++) step();
    quiet(3);

    // Requester 2 sends a 3-pixel burst.
    req_d = 6'b000100;
    step();
    set_pix(2, 10, 20, 12'hF00, 1'b1, 1'b0); step();
    set_pix(2, 11, 20, 12'hF00, 1'b1, 1'b0); step();
    set_pix(2, 12, 20, 12'hF00, 1'b1, 1'b1); step();
    valid_d = '0; last_d = '0;
    quiet(3);

    // Screen boundary pixels.
    req_d = 6'b001000;
    step();
    set_pix(3, 320, 5, 12'h123, 1'b1, 1'b0); step();
    set_pix(3, 5, 240, 12'h456, 1'b1, 1'b0); step();
    set_pix(3, 319, 239, 12'h789, 1'b1, 1'b1); step();
    quiet(3);

    // Stalled burst runs into the timeout; error stays sticky.
    req_d = 6'b010000;
    for (int i = 0; i < TO + 4; i++) step();
    quiet(2);
    req_d = 6'b000001;
    step();
    set_pix(0, 1, 2, 12'hABC, 1'b1, 1'b1); step();
    quiet(3);

    // Reset landing on an accepted pixel.
    req_d = 6'b100000;
    step();
    set_pix(5, 100, 100, 12'hFFF, 1'b1, 1'b0);
    reset_d = 1'b1;
    step();
    reset_d = 1'b0;
    step();
    quiet(2);

    // All requesters with single-pixel bursts: strict rotation.
    exp_next = m_ptr;
    req_d = '1; valid_d = '1; last_d = '1;
    for (int i = 0; i < 21; i++) begin
      prev_phase = m_phase;
      step();
      if (prev_phase == 0 && m_phase == 1) begin
        check("rotation", 32'(gnt), 32'(1 << exp_next));
        exp_next = (exp_next + 1) % N;
      end
    end
    quiet(3);

    // Randomized traffic with periodic stalls.
    for (int c = 0; c < 3000; c++) begin
      rand_inputs((c % 200) >= 170);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
